ula_seq: RTL

Sequencing front end that initiates operations on the team's combinational ALU (`ULA`). It accepts operation requests over a valid/ready handshake and drives registered operands and opcode onto the ALU. After a fixed settle time it captures the result and the O/C/S/Z flags, then returns them over a second valid/ready handshake. It also maintains the architectural flag register and a last-result register for chained operations.

---
 rtl/ula_pkg.sv | 50 +++++
 rtl/ula_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
//   Shared definitions for the ULA sequencing front end and anything that
//   needs to interpret its opcodes or flag vectors.
//
//   Contents:
//     state_t      - sequencer FSM state encoding (IDLE / DRIVE / RESP)
//     op_class_t   - opcode class (arithmetic or logic)
//     FLG_*        - bit positions inside a {O,C,S,Z} flag vector
//     OP_*         - commonly used ALU opcodes
//     CNT_W        - width of the settle counter (SETTLE legal range 1..15)
//     op_class()   - class-select helper decoding OP[5:4]
// ---------------------------------------------------------------------------
package ula_pkg;

   // Sequencer states. DBG_STATE on ula_seq carries this encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   // Opcode class: OP[5:4] == 2'b00 is arithmetic, anything else is logic.
   typedef enum logic {
      CLS_ARITH = 1'b0,
      CLS_LOGIC = 1'b1
   } op_class_t;

   // Bit positions in a 4-bit {O,C,S,Z} flag vector.
   localparam int FLG_O = 3;
   localparam int FLG_C = 2;
   localparam int FLG_S = 1;
   localparam int FLG_Z = 0;

   // Common opcodes.
   localparam logic [5:0] OP_ADD = 6'h00;
   localparam logic [5:0] OP_SUB = 6'h01;
   localparam logic [5:0] OP_AND = 6'h10;
   localparam logic [5:0] OP_OR  = 6'h11;

   // Settle counter width; holds SETTLE-1 for SETTLE up to 15.
   localparam int CNT_W = 4;

   function automatic op_class_t op_class(input logic [5:0] op);
      op_class_t cls;
      cls = (op[5:4] == 2'b00) ? CLS_ARITH : CLS_LOGIC;
      return cls;
   endfunction

endpackage

// File: rtl/ula_seq.sv
// ---------------------------------------------------------------------------
// ula_seq
//   Sequencing front end for the combinational team ALU. A request is taken
//   over a valid/ready handshake, its operands/opcode are registered onto the
//   ALU, held for SETTLE full cycles, and then the ALU result and flags are
//   captured and offered over a second valid/ready handshake. The block also
//   keeps the architectural flag register (FLAGS) and a last-result register
//   (LAST) that a chained request can use in place of operand A.
//
//   Handshake rule (both interfaces): a transfer happens on a rising CLK edge
//   where VALID and READY are both high. REQ_READY is high only in IDLE and
//   RSP_VALID only in RESP; both are decoded from the state register alone, so
//   neither depends combinationally on the partner's VALID/READY. The
//   requester holds REQ_* stable until accepted; RSP_* stay stable until
//   RSP_READY is seen.
//
//   Parameters:
//     BITS    datapath width, must match the connected ALU
//     SETTLE  full cycles the ALU inputs are held before capture (1..15)
//
//   Ports:
//     CLK, RST_N                  clock, asynchronous active-low reset
//     REQ_VALID/REQ_READY         request handshake
//     REQ_OP, REQ_A, REQ_B        opcode and operands
//     REQ_CHAIN                   use LAST in place of REQ_A
//     REQ_FLAG_EN                 commit captured flags into FLAGS
//     ALU_A, ALU_B, ALU_OP        registered operands/opcode to the ALU
//     ALU_RESU, ALU_O/C/S/Z       ALU result and flags
//     RSP_VALID/RSP_READY         response handshake
//     RSP_RESU, RSP_FLAGS         captured result and {O,C,S,Z}
//     FLAGS                       architectural flag register {O,C,S,Z}
//     DBG_STATE                   current FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module ula_seq
   import ula_pkg::*;
#(
   parameter int BITS   = 16,
   parameter int SETTLE = 1
) (
   input  logic            CLK,
   input  logic            RST_N,
   // request side
   input  logic            REQ_VALID,
   output logic            REQ_READY,
   input  logic [5:0]      REQ_OP,
   input  logic [BITS-1:0] REQ_A,
   input  logic [BITS-1:0] REQ_B,
   input  logic            REQ_CHAIN,
   input  logic            REQ_FLAG_EN,
   // ALU side
   output logic [BITS-1:0] ALU_A,
   output logic [BITS-1:0] ALU_B,
   output logic [5:0]      ALU_OP,
   input  logic [BITS-1:0] ALU_RESU,
   input  logic            ALU_O,
   input  logic            ALU_C,
   input  logic            ALU_S,
   input  logic            ALU_Z,
   // response side
   output logic            RSP_VALID,
   input  logic            RSP_READY,
   output logic [BITS-1:0] RSP_RESU,
   output logic [3:0]      RSP_FLAGS,
   // architectural state
   output logic [3:0]      FLAGS,
   // debug
   output logic [1:0]      DBG_STATE
);

   // Counter reload value: the capture happens in the DRIVE cycle where the
   // counter reads zero, which gives SETTLE full cycles of ALU input hold.
   localparam logic [CNT_W-1:0] C_SETTLE_INIT = CNT_W'(SETTLE - 1);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_flag_en;
   logic [BITS-1:0]   r_alu_a;
   logic [BITS-1:0]   r_alu_b;
   logic [5:0]        r_alu_op;
   logic [BITS-1:0]   r_rsp_resu;
   logic [3:0]        r_rsp_flags;
   logic [3:0]        r_flags;
   logic [BITS-1:0]   r_last;

   // ------------------------------------------------------------------------
   // Combinational controls
   // ------------------------------------------------------------------------
   state_t            w_next_state;
   logic              w_accept;
   logic              w_capture;
   logic              w_req_ready;
   logic              w_rsp_valid;
   logic [3:0]        w_alu_flags;

   // Pack the ALU flag pins into the {O,C,S,Z} vector layout.
   always_comb begin
      w_alu_flags        = 4'b0000;
      w_alu_flags[FLG_O] = ALU_O;
      w_alu_flags[FLG_C] = ALU_C;
      w_alu_flags[FLG_S] = ALU_S;
      w_alu_flags[FLG_Z] = ALU_Z;
   end

   // Next-state and handshake decode. Handshake outputs depend on state only.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      w_req_ready  = 1'b0;
      w_rsp_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req_ready = 1'b1;
            if (REQ_VALID) begin
               w_accept     = 1'b1;
               w_next_state = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (r_cnt == '0) begin
               w_capture    = 1'b1;
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            w_rsp_valid = 1'b1;
            if (RSP_READY) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Settle counter: loaded on accept, counts down to zero in DRIVE and then
   // rests at zero until the next accept.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= C_SETTLE_INIT;
      end else if ((r_state == ST_DRIVE) && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // ALU input registers. They are written only on accept, so they keep the
   // last request's values through capture and response until the next one.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_op  <= '0;
         r_flag_en <= 1'b0;
      end else if (w_accept) begin
         r_alu_a   <= REQ_CHAIN ? r_last : REQ_A;
         r_alu_b   <= REQ_B;
         r_alu_op  <= REQ_OP;
         r_flag_en <= REQ_FLAG_EN;
      end
   end

   // ------------------------------------------------------------------------
   // Capture registers. The response pair is written only on capture, which
   // keeps it stable for the whole RESP state however long RSP_READY is low.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_rsp_resu  <= '0;
         r_rsp_flags <= '0;
         r_last      <= '0;
      end else if (w_capture) begin
         r_rsp_resu  <= ALU_RESU;
         r_rsp_flags <= w_alu_flags;
         r_last      <= ALU_RESU;
      end
   end

   // Architectural flags only follow the ALU when the request asked for it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_flags <= '0;
      end else if (w_capture && r_flag_en) begin
         r_flags <= w_alu_flags;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign REQ_READY = w_req_ready;
   assign RSP_VALID = w_rsp_valid;
   assign ALU_A     = r_alu_a;
   assign ALU_B     = r_alu_b;
   assign ALU_OP    = r_alu_op;
   assign RSP_RESU  = r_rsp_resu;
   assign RSP_FLAGS = r_rsp_flags;
   assign FLAGS     = r_flags;
   assign DBG_STATE = r_state;

endmodule
